// File: rtl/bloco_operacional_if.sv
// rtl/bloco_operacional_if.sv - command/status bundle between control unit and datapath
interface bloco_operacional_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] D_rdata;
  logic [DATA_W-1:0] D_wdata;
  logic [DATA_W-1:0] RF_W_data;
  logic              RF_s0;
  logic              RF_s1;
  logic [ADDR_W-1:0] RF_W_addr;
  logic [ADDR_W-1:0] RF_Rp_addr;
  logic [ADDR_W-1:0] RF_Rq_addr;
  logic              RF_W_wr;
  logic              RF_Rp_rd;
  logic              RF_Rq_rd;
  logic              RF_Rp_zero;
  logic              alu_s0;
  logic              alu_s1;
  logic              alu_c;
  logic              alu_v;

  modport master (
    output D_rdata, RF_W_data, RF_s0, RF_s1, RF_W_addr, RF_Rp_addr, RF_Rq_addr,
           RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_s0, alu_s1,
    input  D_wdata, RF_Rp_zero, alu_c, alu_v
  );

  modport slave (
    input  D_rdata, RF_W_data, RF_s0, RF_s1, RF_W_addr, RF_Rp_addr, RF_Rq_addr,
           RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_s0, alu_s1,
    output D_wdata, RF_Rp_zero, alu_c, alu_v
  );
endinterface

// File: rtl/bloco_operacional.sv
// rtl/bloco_operacional.sv - register file, write mux and ALU of the 6-instruction datapath
// Optional carry/overflow flag registers built when DATAPATH_FLAGS_EN is defined.
module bloco_operacional #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bloco_operacional_if.slave   bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] rp;
  logic [DATA_W-1:0] rq;
  logic [DATA_W-1:0] sum_w;
  logic [DATA_W-1:0] diff_w;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    rp     = bus.RF_Rp_rd ? regs_q[bus.RF_Rp_addr] : '0;
    rq     = bus.RF_Rq_rd ? regs_q[bus.RF_Rq_addr] : '0;
    sum_w  = rp + rq;
    diff_w = rp - rq;
    case ({bus.alu_s1, bus.alu_s0})
      2'b00:   alu_res = rp;
      2'b01:   alu_res = sum_w;
      2'b10:   alu_res = diff_w;
      default: alu_res = '0;
    endcase
    case ({bus.RF_s1, bus.RF_s0})
      2'b00:   wr_data = alu_res;
      2'b01:   wr_data = bus.D_rdata;
      2'b10:   wr_data = bus.RF_W_data;
      default: wr_data = '0;
    endcase
  end

  // Reads see regs_q only, so a same-cycle write never bypasses to the read ports.
  always_comb begin
    regs_d = regs_q;
    if (bus.RF_W_wr)
      regs_d[bus.RF_W_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.D_wdata    = rp;
  assign bus.RF_Rp_zero = (rp == '0);

`ifdef DATAPATH_FLAGS_EN
  logic c_q, c_d;
  logic v_q, v_d;

  // Flags follow only ALU add/sub results that are actually written back.
  always_comb begin
    c_d = c_q;
    v_d = v_q;
    if (bus.RF_W_wr && !bus.RF_s1 && !bus.RF_s0) begin
      if ({bus.alu_s1, bus.alu_s0} == 2'b01) begin
        c_d = (sum_w < rp);
        v_d = (rp[DATA_W-1] == rq[DATA_W-1]) && (sum_w[DATA_W-1] != rp[DATA_W-1]);
      end else if ({bus.alu_s1, bus.alu_s0} == 2'b10) begin
        c_d = (rp < rq);
        v_d = (rp[DATA_W-1] != rq[DATA_W-1]) && (diff_w[DATA_W-1] != rp[DATA_W-1]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign bus.alu_c = c_q;
  assign bus.alu_v = v_q;
`else
  assign bus.alu_c = 1'b0;
  assign bus.alu_v = 1'b0;
`endif
endmodule
